dcsg_bus_responder: RTL and testbench
=====================================

DCSG_BUS_RESPONDER -- requirements
Module: dcsg_bus_responder

Interface
REQ-001 SHALL have parameter FAST_IO_G, default 0, meaning 0 = 32 en_clk ticks per write, 1 = 2 ticks per write.
REQ-002 SHALL have port clk, input, 1, sole clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1, reset that is synchronous and active-high.
REQ-004 SHALL have port en_clk_psg_i, input, 1, PSG clock-enable tick; all bus sampling and wait counting advance only when it is 1.
REQ-005 SHALL have port ce_n_i, input, 1, chip enable, active-low.
REQ-006 SHALL have port wr_n_i, input, 1, write strobe, active-low.
REQ-007 SHALL have port data_i, input, 8, write byte.
REQ-008 SHALL have port ready_o, output, 1, 1 = idle or write complete; 0 = write in progress.
REQ-009 SHALL have ports tone0_o, tone1_o and tone2_o, each output, 10, the tone period registers.
REQ-010 SHALL have port noise_ctrl_o, output, 3, with bit2 = white/periodic and bits1:0 = rate.
REQ-011 SHALL have ports vol0_o, vol1_o, vol2_o and vol3_o, each output, 4, attenuation, where 0xF = silent.
REQ-012 SHALL have port noise_reset_o, output, 1, a one-clk pulse on every noise register write.

Function
REQ-013 Handshake FSM SHALL have states IDLE, WAIT and DONE; all transitions occur only on clk edges where en_clk_psg_i=1.
REQ-014 In IDLE, sampling ce_n_i=0 and wr_n_i=0 SHALL capture data_i, drive ready_o=0 from the next clk, load the wait counter with 31 (FAST_IO_G=0) or 1 (FAST_IO_G=1), and enter WAIT.
REQ-015 In IDLE, wr_n_i=0 with ce_n_i=1, or ce_n_i=0 with wr_n_i=1, SHALL be ignored.
REQ-016 In WAIT, each tick SHALL decrement the counter; on the tick where the counter equals 0 the block SHALL commit the captured byte, set ready_o=1 and enter DONE.
REQ-017 ready_o SHALL therefore rise 32 ticks (normal) or 2 ticks (fast) after the sampling tick.
REQ-018 Deasserting ce_n_i or wr_n_i during WAIT SHALL NOT abort the write; the captured byte still commits.
REQ-019 In DONE, the block SHALL stay until a tick samples wr_n_i=1 or ce_n_i=1, then return to IDLE; no new write is accepted before that.
REQ-020 A latch byte (bit7=1) SHALL set the latch register to channel bits6:5 and type bit4 (1 = volume), then write bits3:0 to the addressed register as follows.
REQ-021 For a latch byte addressing tone N, bits3:0 SHALL replace toneN bits3:0.
REQ-022 For a latch byte addressing a volume, bits3:0 SHALL replace that volume.
REQ-023 For a latch byte addressing noise (channel 3, type 0), bits2:0 SHALL replace noise_ctrl_o.
REQ-024 A data byte (bit7=0) addressing a latched tone SHALL write bits5:0 to toneN bits9:4.
REQ-025 A data byte addressing a latched volume SHALL write bits3:0 to the volume.
REQ-026 A data byte addressing latched noise SHALL write bits2:0 to noise_ctrl_o.
REQ-027 Any write to the noise register SHALL pulse noise_reset_o high for exactly one clk, on the commit clk.
REQ-028 Register outputs SHALL change only on the commit clk.
REQ-029 While en_clk_psg_i=0, the FSM, counter and registers SHALL hold.

Reset
REQ-030 reset=1 SHALL force IDLE, counter=0 and ready_o=1.
REQ-031 reset=1 SHALL force tone0_o, tone1_o and tone2_o to 0, noise_ctrl_o to 0, and vol0_o to vol3_o to 0xF.
REQ-032 reset=1 SHALL force noise_reset_o to 0 and the latch register to channel 0 tone.
REQ-033 reset SHALL take effect regardless of en_clk_psg_i.
REQ-034 Asserting reset mid-WAIT SHALL discard the pending byte with no register update.

Structure
REQ-035 Shared package dcsg_pkg SHALL hold the channel/type encodings, the counter width (5), wait-load constants 31 and 1, and the silent-volume constant 0xF.
REQ-036 Latch/data decoding and the register file SHALL live in sub-module dcsg_reg_file; the handshake FSM and counter SHALL live in the top.

Verification
REQ-037 With FAST_IO_G=0 and en_clk every 4th clk, writing 0x8E then 0x0F SHALL give tone0_o=0x0FE, with ready_o low for exactly 32 ticks per write.
REQ-038 With FAST_IO_G=1, writing 0xD5 SHALL give vol2_o=5 with ready_o low for 2 ticks, and all other outputs still at reset values.
REQ-039 Writing 0xE6 SHALL give noise_ctrl_o=6 and a single one-clk noise_reset_o pulse; writing 0x03 next SHALL give noise_ctrl_o=3 and a second pulse.
REQ-040 Holding wr_n_i=0 after ready_o rises SHALL keep ready_o=1 with no second commit; releasing wr_n_i then writing 0x9A SHALL give vol0_o=0xA.
REQ-041 Asserting reset on tick 10 of WAIT for byte 0xA3 SHALL leave tone1_o=0 and ready_o=1, and the next write SHALL be accepted normally.

Source files
------------

// File: rtl/dcsg_pkg.sv
// Shared encodings and constants for the DCSG bus responder: channel/type
// codes, wait counter sizing and reset values of the register file.
package dcsg_pkg;

  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] WAIT_LOAD_NORMAL = 5'd31;
  localparam logic [CNT_W-1:0] WAIT_LOAD_FAST   = 5'd1;
  localparam logic [3:0]       VOL_SILENT       = 4'hF;

  typedef enum logic [1:0] {
    CH_0 = 2'd0,
    CH_1 = 2'd1,
    CH_2 = 2'd2,
    CH_3 = 2'd3
  } chan_e;

  typedef enum logic {
    TYPE_TONE = 1'b0,
    TYPE_VOL  = 1'b1
  } reg_type_e;

  // Layout matches bits 6:4 of a latch byte, so a slice casts straight in.
  typedef struct packed {
    chan_e     chan;
    reg_type_e rtype;
  } latch_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [CNT_W-1:0] wait_load(input logic fast);
    return fast ? WAIT_LOAD_FAST : WAIT_LOAD_NORMAL;
  endfunction

endpackage

// File: rtl/dcsg_reg_file.sv
// Latch/data byte decoder and PSG register file; updates only on the
// single-cycle wr_en strobe issued by the handshake FSM.
module dcsg_reg_file
  import dcsg_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic [9:0] tone0,
  output logic [9:0] tone1,
  output logic [9:0] tone2,
  output logic [2:0] noise_ctrl,
  output logic [3:0] vol0,
  output logic [3:0] vol1,
  output logic [3:0] vol2,
  output logic [3:0] vol3,
  output logic       noise_reset
);

  latch_t           latch_reg;
  latch_t           target;
  logic             is_latch;
  logic             noise_sel;
  logic [2:0]       noise_reg;
  logic             noise_reset_reg;
  logic [2:0][9:0]  tone_bus;
  logic [3:0][3:0]  vol_bus;

  // A latch byte addresses its own target; a data byte reuses the last latch.
  always_comb begin
    is_latch  = wr_data[7];
    target    = is_latch ? latch_t'(wr_data[6:4]) : latch_reg;
    noise_sel = (target.chan == CH_3) && (target.rtype == TYPE_TONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      latch_reg <= '{chan: CH_0, rtype: TYPE_TONE};
    end else if (wr_en && is_latch) begin
      latch_reg <= latch_t'(wr_data[6:4]);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_tone
      logic [9:0] tone_reg;
      always_ff @(posedge clk) begin
        if (reset) begin
          tone_reg <= '0;
        end else if (wr_en && target.rtype == TYPE_TONE && target.chan == chan_e'(2'(gi))) begin
          if (is_latch) tone_reg[3:0] <= wr_data[3:0];
          else          tone_reg[9:4] <= wr_data[5:0];
        end
      end
      assign tone_bus[gi] = tone_reg;
    end

    for (gi = 0; gi < 4; gi++) begin : g_vol
      logic [3:0] vol_reg;
      always_ff @(posedge clk) begin
        if (reset) begin
          vol_reg <= VOL_SILENT;
        end else if (wr_en && target.rtype == TYPE_VOL && target.chan == chan_e'(2'(gi))) begin
          vol_reg <= wr_data[3:0];
        end
      end
      assign vol_bus[gi] = vol_reg;
    end
  endgenerate

  // Pulse is registered so it lines up with the noise_ctrl update.
  always_ff @(posedge clk) begin
    if (reset) begin
      noise_reg       <= '0;
      noise_reset_reg <= 1'b0;
    end else begin
      noise_reset_reg <= wr_en && noise_sel;
      if (wr_en && noise_sel) noise_reg <= wr_data[2:0];
    end
  end

  assign tone0       = tone_bus[0];
  assign tone1       = tone_bus[1];
  assign tone2       = tone_bus[2];
  assign vol0        = vol_bus[0];
  assign vol1        = vol_bus[1];
  assign vol2        = vol_bus[2];
  assign vol3        = vol_bus[3];
  assign noise_ctrl  = noise_reg;
  assign noise_reset = noise_reset_reg;

endmodule

// File: rtl/dcsg_bus_responder.sv
// CPU-side write handshake for the DCSG: samples the bus on PSG ticks, holds
// ready low for the programmed wait, then commits the byte to the register file.
module dcsg_bus_responder
  import dcsg_pkg::*;
#(
  parameter int FAST_IO_G = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en_clk_psg_i,
  input  logic       ce_n_i,
  input  logic       wr_n_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic [9:0] tone0_o,
  output logic [9:0] tone1_o,
  output logic [9:0] tone2_o,
  output logic [2:0] noise_ctrl_o,
  output logic [3:0] vol0_o,
  output logic [3:0] vol1_o,
  output logic [3:0] vol2_o,
  output logic [3:0] vol3_o,
  output logic       noise_reset_o
);

  localparam logic [CNT_W-1:0] LOAD_VAL = wait_load(FAST_IO_G != 0);

  state_e           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [7:0]       data_reg, data_next;
  logic             ready_reg, ready_next;
  logic             commit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      data_reg  <= '0;
      ready_reg <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      data_reg  <= data_next;
      ready_reg <= ready_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    data_next  = data_reg;
    ready_next = ready_reg;
    commit     = 1'b0;
    if (en_clk_psg_i) begin
      case (state_reg)
        ST_IDLE: begin
          if (!ce_n_i && !wr_n_i) begin
            data_next  = data_i;
            cnt_next   = LOAD_VAL;
            ready_next = 1'b0;
            state_next = ST_WAIT;
          end
        end
        // Bus release during the wait is deliberately ignored.
        ST_WAIT: begin
          if (cnt_reg == '0) begin
            commit     = 1'b1;
            ready_next = 1'b1;
            state_next = ST_DONE;
          end else begin
            cnt_next = cnt_reg - CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (wr_n_i || ce_n_i) state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign ready_o = ready_reg;

  dcsg_reg_file u_reg_file (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (commit),
    .wr_data     (data_reg),
    .tone0       (tone0_o),
    .tone1       (tone1_o),
    .tone2       (tone2_o),
    .noise_ctrl  (noise_ctrl_o),
    .vol0        (vol0_o),
    .vol1        (vol1_o),
    .vol2        (vol2_o),
    .vol3        (vol3_o),
    .noise_reset (noise_reset_o)
  );

endmodule

// File: tb/tb_dcsg_bus_responder.sv
// Directed bench: a normal-speed and a fast-I/O responder share one bus and
// are driven with the same write sequence; expected values are hand-computed.
module tb_dcsg_bus_responder;

  logic       clk;
  logic       reset;
  logic       en;
  logic       ce_n;
  logic       wr_n;
  logic [7:0] data;
  logic [1:0] div = 2'd0;

  logic       ready_n, ready_f;
  logic [9:0] tone0_n, tone1_n, tone2_n, tone0_f, tone1_f, tone2_f;
  logic [2:0] noise_n, noise_f;
  logic [3:0] vol0_n, vol1_n, vol2_n, vol3_n, vol0_f, vol1_f, vol2_f, vol3_f;
  logic       nrst_n, nrst_f;

  int n_vec = 0;
  int n_err = 0;
  int pulses_n = 0;
  int pulses_f = 0;

  dcsg_bus_responder #(.FAST_IO_G(0)) dut_norm (
    .clk(clk), .reset(reset), .en_clk_psg_i(en), .ce_n_i(ce_n), .wr_n_i(wr_n),
    .data_i(data), .ready_o(ready_n), .tone0_o(tone0_n), .tone1_o(tone1_n),
    .tone2_o(tone2_n), .noise_ctrl_o(noise_n), .vol0_o(vol0_n), .vol1_o(vol1_n),
    .vol2_o(vol2_n), .vol3_o(vol3_n), .noise_reset_o(nrst_n)
  );

  dcsg_bus_responder #(.FAST_IO_G(1)) dut_fast (
    .clk(clk), .reset(reset), .en_clk_psg_i(en), .ce_n_i(ce_n), .wr_n_i(wr_n),
    .data_i(data), .ready_o(ready_f), .tone0_o(tone0_f), .tone1_o(tone1_f),
    .tone2_o(tone2_f), .noise_ctrl_o(noise_f), .vol0_o(vol0_f), .vol1_o(vol1_f),
    .vol2_o(vol2_f), .vol3_o(vol3_f), .noise_reset_o(nrst_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PSG tick on every 4th clk.
  always @(posedge clk) div <= div + 2'd1;
  assign en = (div == 2'd3);

  always @(negedge clk) begin
    if (nrst_n) pulses_n <= pulses_n + 1;
    if (nrst_f) pulses_f <= pulses_f + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_norm(input logic [9:0] t0, input logic [9:0] t1, input logic [9:0] t2,
                            input logic [2:0] nz, input logic [3:0] v0, input logic [3:0] v1,
                            input logic [3:0] v2, input logic [3:0] v3);
    check("norm_tone0", 32'(tone0_n), 32'(t0));
    check("norm_tone1", 32'(tone1_n), 32'(t1));
    check("norm_tone2", 32'(tone2_n), 32'(t2));
    check("norm_noise", 32'(noise_n), 32'(nz));
    check("norm_vol0",  32'(vol0_n),  32'(v0));
    check("norm_vol1",  32'(vol1_n),  32'(v1));
    check("norm_vol2",  32'(vol2_n),  32'(v2));
    check("norm_vol3",  32'(vol3_n),  32'(v3));
  endtask

  task automatic check_fast(input logic [9:0] t0, input logic [9:0] t1, input logic [9:0] t2,
                            input logic [2:0] nz, input logic [3:0] v0, input logic [3:0] v1,
                            input logic [3:0] v2, input logic [3:0] v3);
    check("fast_tone0", 32'(tone0_f), 32'(t0));
    check("fast_tone1", 32'(tone1_f), 32'(t1));
    check("fast_tone2", 32'(tone2_f), 32'(t2));
    check("fast_noise", 32'(noise_f), 32'(nz));
    check("fast_vol0",  32'(vol0_f),  32'(v0));
    check("fast_vol1",  32'(vol1_f),  32'(v1));
    check("fast_vol2",  32'(vol2_f),  32'(v2));
    check("fast_vol3",  32'(vol3_f),  32'(v3));
  endtask

  // Called at a negedge; returns at the negedge just after the next tick edge.
  task automatic wait_tick();
    int g = 0;
    while (!en && g < 8) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
  endtask

  // Drives one write; counts ticks each DUT shows ready low. rst_tick > 0
  // asserts reset on that tick of the wait instead of completing the write.
  task automatic write_byte(input logic [7:0] d, input int hold_ticks, input int rst_tick,
                            output int low_n, output int low_f);
    int  k = 0;
    int  g = 0;
    int  hold_low = 0;
    bit  done = 0;
    bit  rst_done = 0;
    low_n = 0;
    low_f = 0;
    @(negedge clk);
    ce_n = 1'b0;
    wr_n = 1'b0;
    data = d;
    while (!en && g < 8) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    for (int g2 = 0; g2 < 400 && !done; g2++) begin
      if (en) begin
        k++;
        if (rst_tick == k) begin
          reset = 1'b1;
          @(negedge clk);
          reset = 1'b0;
          ce_n = 1'b1;
          wr_n = 1'b1;
          rst_done = 1;
          done = 1;
        end else if (ready_n && ready_f) begin
          done = 1;
        end else begin
          if (!ready_n) low_n++;
          if (!ready_f) low_f++;
        end
      end
      if (!done) @(negedge clk);
    end
    if (!done) check("write_timeout", 32'(0), 32'(1));
    if (rst_done) begin
      $display("wr %02h: reset asserted on wait tick %0d", d, rst_tick);
    end else begin
      for (int h = 0; h < hold_ticks; h++) begin
        g = 0;
        while (!en && g < 8) begin
          @(negedge clk);
          g++;
        end
        if (!ready_n || !ready_f) hold_low++;
        @(negedge clk);
      end
      if (hold_ticks > 0) check("hold_ready_low_ticks", 32'(hold_low), 32'(0));
      ce_n = 1'b1;
      wr_n = 1'b1;
      wait_tick();
      wait_tick();
      $display("wr %02h: ready low norm=%0d fast=%0d", d, low_n, low_f);
    end
  endtask

  // Holds a non-qualifying strobe combination for a few ticks.
  task automatic poke_ignored(input logic ce_v, input logic wr_v, input logic [7:0] d);
    int lows = 0;
    @(negedge clk);
    ce_n = ce_v;
    wr_n = wr_v;
    data = d;
    for (int t = 0; t < 4; t++) begin
      wait_tick();
      if (!ready_n || !ready_f) lows++;
    end
    ce_n = 1'b1;
    wr_n = 1'b1;
    check("ignored_ready_low", 32'(lows), 32'(0));
    $display("poke ce_n=%0b wr_n=%0b data=%02h: ready low ticks=%0d", ce_v, wr_v, d, lows);
  endtask

  initial begin
    int ln, lf, p_n, p_f;
    reset = 1'b1;
    ce_n  = 1'b1;
    wr_n  = 1'b1;
    data  = 8'h00;
    repeat (6) @(negedge clk);
    reset = 1'b0;

    check("reset_ready_norm", 32'(ready_n), 32'(1));
    check("reset_ready_fast", 32'(ready_f), 32'(1));
    check("reset_nrst_norm", 32'(nrst_n), 32'(0));
    check_norm(10'h000, 10'h000, 10'h000, 3'd0, 4'hF, 4'hF, 4'hF, 4'hF);

    write_byte(8'hD5, 0, 0, ln, lf);
    check("d5_low_fast", 32'(lf), 32'(2));
    check("d5_low_norm", 32'(ln), 32'(32));
    check_fast(10'h000, 10'h000, 10'h000, 3'd0, 4'hF, 4'hF, 4'h5, 4'hF);
    check("d5_nrst_pulses_fast", 32'(pulses_f), 32'(0));

    write_byte(8'h8E, 0, 0, ln, lf);
    check("8e_low_norm", 32'(ln), 32'(32));
    check("8e_tone0_norm", 32'(tone0_n), 32'(10'h00E));
    write_byte(8'h0F, 0, 0, ln, lf);
    check("0f_low_norm", 32'(ln), 32'(32));
    check("0f_low_fast", 32'(lf), 32'(2));
    check_norm(10'h0FE, 10'h000, 10'h000, 3'd0, 4'hF, 4'hF, 4'h5, 4'hF);
    check("0f_tone0_fast", 32'(tone0_f), 32'(10'h0FE));

    poke_ignored(1'b1, 1'b0, 8'h81);
    poke_ignored(1'b0, 1'b1, 8'h81);
    check("ignored_tone0_norm", 32'(tone0_n), 32'(10'h0FE));

    p_n = pulses_n;
    p_f = pulses_f;
    write_byte(8'hE6, 0, 0, ln, lf);
    check("e6_noise_norm", 32'(noise_n), 32'(6));
    check("e6_noise_fast", 32'(noise_f), 32'(6));
    check("e6_pulse_norm", 32'(pulses_n - p_n), 32'(1));
    check("e6_pulse_fast", 32'(pulses_f - p_f), 32'(1));
    write_byte(8'h03, 0, 0, ln, lf);
    check("03_noise_norm", 32'(noise_n), 32'(3));
    check("03_pulse_norm", 32'(pulses_n - p_n), 32'(2));
    check("03_pulse_fast", 32'(pulses_f - p_f), 32'(2));
    check("03_tone0_norm", 32'(tone0_n), 32'(10'h0FE));

    p_n = pulses_n;
    write_byte(8'h91, 8, 0, ln, lf);
    check("91_vol0_norm", 32'(vol0_n), 32'(1));
    check("91_vol0_fast", 32'(vol0_f), 32'(1));
    write_byte(8'h9A, 0, 0, ln, lf);
    check("9a_low_norm", 32'(ln), 32'(32));
    check_norm(10'h0FE, 10'h000, 10'h000, 3'd3, 4'hA, 4'hF, 4'h5, 4'hF);
    check("vol_writes_no_pulse", 32'(pulses_n - p_n), 32'(0));

    write_byte(8'hA3, 0, 10, ln, lf);
    check("a3_rst_ready_norm", 32'(ready_n), 32'(1));
    check("a3_rst_ready_fast", 32'(ready_f), 32'(1));
    wait_tick();
    wait_tick();
    check_norm(10'h000, 10'h000, 10'h000, 3'd0, 4'hF, 4'hF, 4'hF, 4'hF);

    write_byte(8'hC7, 0, 0, ln, lf);
    check("c7_low_norm", 32'(ln), 32'(32));
    check("c7_low_fast", 32'(lf), 32'(2));
    check_norm(10'h000, 10'h000, 10'h007, 3'd0, 4'hF, 4'hF, 4'hF, 4'hF);
    check_fast(10'h000, 10'h000, 10'h007, 3'd0, 4'hF, 4'hF, 4'hF, 4'hF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
